// File: rtl/fetch_queue.sv
// ============================================================================
//  fetch_queue
//  Decoupling FIFO of four-instruction fetch packets between fetch and decode.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_queue #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_fq,
  input  logic             valid_if,
  input  logic [3:0][31:0] pc_if,
  input  logic [3:0][31:0] inst_if,
  input  logic [3:0]       mask_if,
  input  logic             predict_if,
  input  logic [31:0]      target_if,
  output logic             stall_fq,
  output logic             valid_id,
  input  logic             ready_id,
  output logic [3:0][31:0] pc_id,
  output logic [3:0][31:0] inst_id,
  output logic [3:0]       mask_id,
  output logic             predict_id,
  output logic [31:0]      target_id
);

  localparam int            AW        = $clog2(DEPTH);
  localparam int            CW        = AW + 1;
  localparam logic [CW-1:0] C_DEPTH   = CW'(DEPTH);
  localparam logic [CW-1:0] C_STALL_AT = CW'(DEPTH - 1);

  logic [3:0][31:0] r_pc     [DEPTH];
  logic [3:0][31:0] r_inst   [DEPTH];
  logic [3:0]       r_mask   [DEPTH];
  logic             r_predict[DEPTH];
  logic [31:0]      r_target [DEPTH];

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_stall;

  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_next;

  assign valid_id = (r_count != '0);
  assign w_pop    = valid_id && ready_id;
  // A full queue still accepts when the head leaves in the same cycle.
  assign w_push   = valid_if && (mask_if != 4'b0000) && ((r_count < C_DEPTH) || w_pop);

  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_stall <= 1'b0;
    end else if (flush_fq) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_stall <= 1'b0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + AW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + AW'(1);
      end
      r_count <= w_count_next;
      // One spare entry absorbs the packet already in flight from the PC stage.
      r_stall <= (w_count_next >= C_STALL_AT);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush_fq) begin
      r_pc[r_tail]      <= pc_if;
      r_inst[r_tail]    <= inst_if;
      r_mask[r_tail]    <= mask_if;
      r_predict[r_tail] <= predict_if;
      r_target[r_tail]  <= target_if;
    end
  end

  assign stall_fq   = r_stall;
  assign pc_id      = r_pc[r_head];
  assign inst_id    = r_inst[r_head];
  assign mask_id    = r_mask[r_head];
  assign predict_id = r_predict[r_head];
  assign target_id  = r_target[r_head];

endmodule

`default_nettype wire

// File: doc/fetch_queue.md
# fetch_queue

Decoupling FIFO between instruction fetch and decode. Each cycle it accepts one fetch packet of four sequential instructions: a base PC, four 32-bit words, a per-slot valid mask and the BPU prediction. It hands the oldest packet to decode under a valid/ready handshake. It drives stall_fq back to the PC stage when it cannot accept, and empties on any pipeline flush (branch, exception, ertn, idle).

## Interface
- DEPTH, 8: packet entries; power of two, ≥2.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- flush_fq  in  1  OR of branch/excp/ertn/idle flushes; clears queue.
- valid_if  in  1  fetch packet present this cycle.
- pc_if  in  4×32  PCs of the four slots (pc, pc+4, pc+8, pc+12).
- inst_if  in  4×32  instruction words.
- mask_if  in  4  slot valid bits; a slot is 0 when it follows a predicted-taken branch or precedes an unaligned entry.
- predict_if  in  1  BPU predicted taken for this packet.
- target_if  in  32  predicted target.
- stall_fq  out  1  queue cannot accept next cycle; PC holds.
- valid_id  out  1  head packet valid.
- ready_id  in  1  decode consumes the head this cycle.
- pc_id  out  4×32  head PCs.
- inst_id  out  4×32  head instructions.
- mask_id  out  4  head slot mask.
- predict_id  out  1  head prediction flag.
- target_id  out  32  head predicted target.

## Operation
- Storage: DEPTH-entry circular buffer, with head/tail pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Push: push = valid_if && (mask_if != 0) && (count < DEPTH || pop). The packet is written at tail, and tail then increments. A packet with an all-zero mask is dropped and never occupies an entry.
- Pop: pop = valid_id && ready_id. Head increments.
- count_next = count + push − pop. Push and pop may occur in the same cycle at any count, including full (pass-through with count unchanged) and count==1.
- Outputs *_id are read combinationally from the entry at head. valid_id = (count != 0).
- stall_fq = (count_next ≥ DEPTH−1), registered. This margin of one entry covers the single-cycle PC-to-fetch latency, so a packet already in flight is never lost.
- Flush: when flush_fq=1, the next state is head=tail=0, count=0, stall_fq=0. Any push or pop in that cycle is ignored. Entry contents are not cleared.
- Reset: head=tail=count=0, stall_fq=0, valid_id=0. *_id data outputs are don't-care while valid_id=0.
- Priority, highest first: reset, flush_fq, push/pop.

## Timing
- Latency: a packet pushed in cycle N appears on *_id in cycle N+1 when the queue was empty; there is no same-cycle bypass.
- stall_fq is registered. It rises the cycle after count_next reaches DEPTH−1 and falls the cycle after count_next drops below DEPTH−1.
- Decode may hold ready_id low indefinitely. *_id stay stable while the head is unpopped.
- Flush takes effect at the clock edge, so valid_id=0 in the cycle after flush_fq.
- Asserting rst mid-operation forces the reset state immediately. The first push is accepted on the first edge after release.

## Test plan
- Single packet: reset, push pc_if base 0x1C000000, mask 4'b1111, ready_id=1.
  - Required: valid_id=1 one cycle later with pc_id[0]=0x1C000000 and pc_id[3]=0x1C00000C; count returns to 0 after the pop.
- Fill/stall with DEPTH=8: push every cycle, ready_id=0.
  - Required: stall_fq=1 the cycle after the 7th push; the 8th push is accepted; a 9th push is rejected and count stays 8.
- Full pass-through: at count=8, valid_if=1 and ready_id=1 for 5 cycles.
  - Required: every push accepted, count stays 8, outputs in strict FIFO order across the head/tail wrap.
- Flush mid-stream: count=5, then flush_fq=1 together with valid_if=1 and ready_id=1.
  - Required: next cycle count=0, valid_id=0, stall_fq=0; the concurrent packet is discarded.
- Empty mask and prediction carry: push mask_if=0.
  - Required: nothing enqueued.
  - Then push mask_if=4'b0011, predict_if=1, target_if=0x1C000100. Required: mask_id=0011, predict_id=1, target_id=0x1C000100.
- Async reset: assert rst low mid-cycle at count=3.
  - Required: valid_id and stall_fq drop immediately without waiting for a clock edge.
